voice_allocator: RTL

- Parametrised successor to the fixed 8-voice note dispatch between midi_decoder and synth_engine.
- Accepts decoded MIDI note events over a valid/ready handshake and assigns each to a voice slot.
- Assignment order: same-key retrigger, then free, then released, then oldest-held steal; uses a per-voice LRU rank.
- Drives keys_on, cur_key_adr and note strobes to the synth_engine; consumes voice_free from the envelope generators.

---
 rtl/voice_allocator.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to VOICES voice slots (retrigger, free, released, steal).
// Sustain-pedal handling is compiled in with `define VOICE_ALLOC_SUSTAIN_EN.
module voice_allocator #(
    parameter int unsigned VOICES       = 8,
    parameter int unsigned V_WIDTH      = $clog2(VOICES),
    parameter bit          VEL_ZERO_OFF = 1'b1
) (
    input  logic               CLOCK_25,
    input  logic               iRST,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [6:0]         ev_key,
    input  logic [6:0]         ev_vel,
    input  logic [VOICES-1:0]  voice_free,
    input  logic               sustain,
    output logic               note_on,
    output logic               note_off,
    output logic               steal,
    output logic [VOICES-1:0]  keys_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off,
    output logic [V_WIDTH:0]   active_keys,
    output logic               off_note_error
);

`ifdef VOICE_ALLOC_SUSTAIN_EN
    typedef enum logic [1:0] {StIdle, StScan, StIssue, StSusRel} state_t;
`else
    typedef enum logic [1:0] {StIdle, StScan, StIssue} state_t;
`endif

    // Candidate classes, lower value wins; CL_NONE marks "no candidate yet".
    localparam logic [2:0] CL_HIT  = 3'd0;
    localparam logic [2:0] CL_FREE = 3'd1;
    localparam logic [2:0] CL_REL  = 3'd2;
    localparam logic [2:0] CL_HELD = 3'd3;
    localparam logic [2:0] CL_NONE = 3'd4;

    state_t             state;
    logic [V_WIDTH-1:0] scan_idx;
    logic [6:0]         key_q;
    logic [6:0]         vel_q;
    logic               off_q;
    logic [6:0]         key_store [VOICES];
    logic [V_WIDTH-1:0] rank      [VOICES];
    logic [V_WIDTH-1:0] best_v;
    logic [V_WIDTH-1:0] best_rank;
    logic [2:0]         best_class;

    logic               hit;
    logic [2:0]         cand_class;
    logic               better;
    logic [V_WIDTH:0]   pop;
    logic               scan_last;

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic [VOICES-1:0]  sus_q;
    logic               sustain_q;
    logic               sus_pend;

    assign ev_ready = (state == StIdle) && !sus_pend;
`else
    logic               unused_sustain;

    assign unused_sustain = sustain;
    assign ev_ready       = (state == StIdle);
`endif

    assign scan_last = (scan_idx == V_WIDTH'(VOICES - 1));

    always_comb begin
        hit = keys_on[scan_idx] && (key_store[scan_idx] == key_q);
        if (off_q) begin
            cand_class = hit ? CL_HIT : CL_NONE;
        end else if (hit) begin
            cand_class = CL_HIT;
        end else if (!keys_on[scan_idx]) begin
            cand_class = voice_free[scan_idx] ? CL_FREE : CL_REL;
        end else begin
            cand_class = CL_HELD;
        end
        // Ranks are unique, so the strict compare never needs a tie-break.
        better = (cand_class < best_class) ||
                 ((cand_class == best_class) && (cand_class != CL_NONE) &&
                  (rank[scan_idx] > best_rank));
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(VOICES); i++) begin
            pop = pop + {{V_WIDTH{1'b0}}, keys_on[i]};
        end
    end

    always_ff @(posedge CLOCK_25 or posedge iRST) begin
        if (iRST) begin
            state          <= StIdle;
            scan_idx       <= '0;
            key_q          <= '0;
            vel_q          <= '0;
            off_q          <= 1'b0;
            best_v         <= '0;
            best_rank      <= '0;
            best_class     <= CL_NONE;
            keys_on        <= '0;
            active_keys    <= '0;
            note_on        <= 1'b0;
            note_off       <= 1'b0;
            steal          <= 1'b0;
            off_note_error <= 1'b0;
            cur_key_adr    <= '0;
            cur_key_val    <= '0;
            cur_vel_on     <= '0;
            cur_vel_off    <= '0;
            for (int i = 0; i < int'(VOICES); i++) begin
                key_store[i] <= '0;
                rank[i]      <= V_WIDTH'(i);
            end
`ifdef VOICE_ALLOC_SUSTAIN_EN
            sus_q     <= '0;
            sustain_q <= 1'b0;
            sus_pend  <= 1'b0;
`endif
        end else begin
            note_on        <= 1'b0;
            note_off       <= 1'b0;
            steal          <= 1'b0;
            off_note_error <= 1'b0;
            active_keys    <= pop;
            case (state)
                StIdle: begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    if (sus_pend) begin
                        sus_pend <= 1'b0;
                        scan_idx <= '0;
                        state    <= StSusRel;
                    end else
`endif
                    if (ev_valid) begin
                        key_q      <= ev_key;
                        vel_q      <= ev_vel;
                        off_q      <= !ev_on || (VEL_ZERO_OFF && (ev_vel == 7'd0));
                        scan_idx   <= '0;
                        best_v     <= '0;
                        best_rank  <= '0;
                        best_class <= CL_NONE;
                        state      <= StScan;
                    end
                end
                StScan: begin
                    if (better) begin
                        best_class <= cand_class;
                        best_rank  <= rank[scan_idx];
                        best_v     <= scan_idx;
                    end
                    if (scan_last) state <= StIssue;
                    else scan_idx <= scan_idx + V_WIDTH'(1);
                end
                StIssue: begin
                    state <= StIdle;
                    if (!off_q) begin
                        keys_on[best_v]   <= 1'b1;
                        key_store[best_v] <= key_q;
                        note_on           <= 1'b1;
                        steal             <= (best_class == CL_HELD);
                        cur_key_adr       <= best_v;
                        cur_key_val       <= {1'b0, key_q};
                        cur_vel_on        <= {1'b0, vel_q};
                        // Move-to-front: everything younger than v ages by one.
                        for (int i = 0; i < int'(VOICES); i++) begin
                            if (rank[i] < rank[best_v]) rank[i] <= rank[i] + V_WIDTH'(1);
                        end
                        rank[best_v] <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        sus_q[best_v] <= 1'b0;
`endif
                    end else if (best_class != CL_HIT) begin
                        off_note_error <= 1'b1;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    end else if (sustain) begin
                        sus_q[best_v] <= 1'b1;
`endif
                    end else begin
                        keys_on[best_v] <= 1'b0;
                        note_off        <= 1'b1;
                        cur_key_adr     <= best_v;
                        cur_key_val     <= {1'b0, key_q};
                        cur_vel_off     <= {1'b0, vel_q};
                    end
                end
`ifdef VOICE_ALLOC_SUSTAIN_EN
                StSusRel: begin
                    if (sus_q[scan_idx]) begin
                        keys_on[scan_idx] <= 1'b0;
                        sus_q[scan_idx]   <= 1'b0;
                        note_off          <= 1'b1;
                        cur_key_adr       <= scan_idx;
                        cur_key_val       <= {1'b0, key_store[scan_idx]};
                    end
                    if (scan_last) state <= StIdle;
                    else scan_idx <= scan_idx + V_WIDTH'(1);
                end
`endif
                default: state <= StIdle;
            endcase
`ifdef VOICE_ALLOC_SUSTAIN_EN
            // Placed after the FSM so a new pedal release is never lost to the clear above.
            sustain_q <= sustain;
            if (sustain_q && !sustain) sus_pend <= 1'b1;
`endif
        end
    end

endmodule
